bcd_convert: RTL and testbench
==============================

# bcd_convert

Parametrised sequential binary-to-BCD converter (shift-and-add-3). It accepts a WIDTH-bit operand on a start strobe and converts it over WIDTH clock cycles. The operand is treated as signed or unsigned per request. The block returns sign, DIGITS packed BCD digits and an overflow flag with a one-cycle data_ready pulse. It is the generalised successor to the fixed 8-bit, 3-digit converter that feeds the display path, and serves any operand width and digit count.

## Interface
- WIDTH, 8: operand width in bits; legal range 4..32.
- DIGITS, 3: number of BCD output digits; legal range 1..10.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- is_signed  input  1  1 = binary is two's complement; sampled with start.
- binary  input  WIDTH  operand; sampled on the accepting edge.
- sign  output  1  1 = result negative.
- bcd  output  4*DIGITS  packed digits; bcd[3:0] = ones, bcd[7:4] = tens, and so on.
- overflow  output  1  1 = magnitude exceeds 10^DIGITS-1.
- busy  output  1  conversion in progress.
- data_ready  output  1  one-cycle pulse when sign, bcd and overflow are updated.

## Operation
- States:
  - IDLE → SHIFT on start=1.
  - SHIFT → DONE after WIDTH shift cycles.
  - DONE → IDLE unconditionally.
- Accept edge (IDLE, start=1):
  - Magnitude register = (is_signed && binary[WIDTH-1]) ? (~binary+1) : binary, computed in WIDTH bits unsigned.
  - The most-negative value, e.g. 0x80 for WIDTH=8, yields magnitude 2^(WIDTH-1); this is correct.
  - Latch pending sign = is_signed && binary[WIDTH-1].
  - Clear scratch digits and the sticky overflow; load iteration counter with WIDTH.
- Each SHIFT cycle:
  - Every scratch digit ≥5 gets +3.
  - Then {scratch, magnitude} shifts left by 1.
  - The bit shifted out of the top digit ORs into sticky overflow.
  - Counter decrements.
- Truncation: lower digits stay exact, so bcd = magnitude mod 10^DIGITS when overflow=1.
- DONE:
  - sign, bcd and overflow registers load from scratch/pending values.
  - data_ready=1 for exactly this cycle.
- Outputs hold the last result until the next DONE; start does not clear them.
- Negative zero cannot occur; sign=0 for a zero result.
- start while in SHIFT or DONE is ignored, not queued.
- is_signed=0: binary is unsigned; sign is always 0.

## Timing
- Reset (rst=0, asynchronous): state IDLE; sign=0, bcd=0, overflow=0, busy=0, data_ready=0; scratch and counter cleared.
- Reset mid-conversion aborts without a data_ready pulse; outputs return to 0.
- Deassertion of rst is synchronised by the system; the first active edge after release may accept start.
- Let E0 be the edge accepting start:
  - busy=1 from after E0 through the DONE cycle, and falls after E(WIDTH+2).
  - Shifts occur at edges E1..EWIDTH.
  - DONE is the cycle after EWIDTH; outputs update and data_ready=1 after E(WIDTH+1).
- Latency is WIDTH+1 cycles from E0 to data_ready visible; throughput is one conversion per WIDTH+2 cycles.
- Earliest next accept is E(WIDTH+2), when start=1 is held during the DONE cycle's following IDLE.
- busy and data_ready are registered outputs; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, DIGITS=3, unsigned:
  - binary=123, start pulse → bcd=0x123, sign=0, overflow=0; data_ready exactly 9 cycles after the accept edge, high 1 cycle.
  - Then binary=38 → bcd=0x038.
- Unsigned vs signed, WIDTH=8:
  - binary=0xFF, is_signed=0 → bcd=0x255, sign=0.
  - is_signed=1 → bcd=0x001, sign=1.
  - binary=0x80, is_signed=1 → bcd=0x128, sign=1.
- Overflow, DIGITS=2, WIDTH=8:
  - binary=123 → bcd=0x23, overflow=1.
  - binary=99 → bcd=0x99, overflow=0.
- Wide instance, WIDTH=16, DIGITS=5:
  - binary=65535 unsigned → bcd=0x65535; data_ready 17 cycles after accept.
  - binary=0x8000 signed → bcd=0x32768, sign=1.
- Start while busy, WIDTH=8:
  - Accept 200, then pulse start with binary=7 during SHIFT → single result 0x200, one data_ready; busy never drops early.
- Reset mid-op:
  - rst low 4 cycles after accepting 123 → all outputs 0 immediately, no data_ready.
  - A new conversion of 45 after release → 0x045.

Source files
------------

// File: rtl/bcd_convert.sv
// bcd_convert: sequential shift-and-add-3 binary-to-BCD converter with optional
// two's-complement input, truncating to DIGITS digits with a sticky overflow flag.
module bcd_convert #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  is_signed,
    input  logic [WIDTH-1:0]      binary,
    output logic                  sign,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic                  busy,
    output logic                  data_ready
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] mag_in;
    logic             neg_in;
    logic [BW-1:0]    scratch;
    logic [BW-1:0]    adjusted;
    logic [CW-1:0]    cnt;
    logic             pend_sign;
    logic             sticky;

    logic             accept;
    logic             busy_next;
    logic             ready_next;
    logic             load_result;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the last shift happens when the counter is at one
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control decode; busy covers the accept edge through the DONE cycle
    always_comb begin
        accept      = 1'b0;
        busy_next   = 1'b0;
        ready_next  = 1'b0;
        load_result = 1'b0;
        if (state == IDLE) begin
            accept    = start;
            busy_next = start;
        end else begin
            busy_next = 1'b1;
        end
        if (state == DONE) begin
            ready_next  = 1'b1;
            load_result = 1'b1;
        end
    end

    // Operand sign and magnitude; most-negative value maps to 2^(WIDTH-1)
    always_comb begin
        neg_in = is_signed & binary[WIDTH-1];
        mag_in = neg_in ? (~binary + WIDTH'(1)) : binary;
    end

    // Add 3 to every scratch digit that is 5 or more before the shift
    always_comb begin
        adjusted = scratch;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion datapath: load on accept, shift {scratch, mag} while in SHIFT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mag       <= '0;
            scratch   <= '0;
            cnt       <= '0;
            pend_sign <= 1'b0;
            sticky    <= 1'b0;
        end else if (accept) begin
            mag       <= mag_in;
            scratch   <= '0;
            cnt       <= CW'(WIDTH);
            pend_sign <= neg_in;
            sticky    <= 1'b0;
        end else if (state == SHIFT) begin
            scratch   <= {adjusted[BW-2:0], mag[WIDTH-1]};
            mag       <= {mag[WIDTH-2:0], 1'b0};
            sticky    <= sticky | adjusted[BW-1];
            cnt       <= cnt - CW'(1);
        end
    end

    // Registered outputs; results hold until the next DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sign       <= 1'b0;
            bcd        <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
            data_ready <= 1'b0;
        end else begin
            busy       <= busy_next;
            data_ready <= ready_next;
            if (load_result) begin
                sign     <= pend_sign;
                bcd      <= scratch;
                overflow <= sticky;
            end
        end
    end

endmodule

// File: tb/tb_bcd_convert.sv
// Directed testbench for bcd_convert: three instances (8b/3d, 8b/2d, 16b/5d).
module tb_bcd_convert;

    logic clk;
    logic rst;

    // Instance A: WIDTH=8, DIGITS=3
    logic        sa, sga;
    logic [7:0]  ba;
    logic        sign_a, ov_a, busy_a, rdy_a;
    logic [11:0] bcd_a;

    // Instance B: WIDTH=8, DIGITS=2
    logic        sb, sgb;
    logic [7:0]  bb;
    logic        sign_b, ov_b, busy_b, rdy_b;
    logic [7:0]  bcd_b;

    // Instance C: WIDTH=16, DIGITS=5
    logic        sc, sgc;
    logic [15:0] bc;
    logic        sign_c, ov_c, busy_c, rdy_c;
    logic [19:0] bcd_c;

    int errors = 0;
    int checks = 0;

    bcd_convert #(.WIDTH(8), .DIGITS(3)) dut_a (
        .clk(clk), .rst(rst), .start(sa), .is_signed(sga), .binary(ba),
        .sign(sign_a), .bcd(bcd_a), .overflow(ov_a), .busy(busy_a), .data_ready(rdy_a)
    );

    bcd_convert #(.WIDTH(8), .DIGITS(2)) dut_b (
        .clk(clk), .rst(rst), .start(sb), .is_signed(sgb), .binary(bb),
        .sign(sign_b), .bcd(bcd_b), .overflow(ov_b), .busy(busy_b), .data_ready(rdy_b)
    );

    bcd_convert #(.WIDTH(16), .DIGITS(5)) dut_c (
        .clk(clk), .rst(rst), .start(sc), .is_signed(sgc), .binary(bc),
        .sign(sign_c), .bcd(bcd_c), .overflow(ov_c), .busy(busy_c), .data_ready(rdy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy_of(input int sel);
        case (sel)
            0:       return rdy_a;
            1:       return rdy_b;
            default: return rdy_c;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    // One conversion: checks busy, latency, single-cycle ready, busy release
    task automatic convert(input int sel, input logic [15:0] val, input logic sgn,
                           input int exp_lat, input string tag,
                           output logic [19:0] bcd_o, output logic s_o, output logic ov_o);
        int lat;
        @(negedge clk);
        case (sel)
            0:       begin ba = val[7:0]; sga = sgn; sa = 1'b1; end
            1:       begin bb = val[7:0]; sgb = sgn; sb = 1'b1; end
            default: begin bc = val;      sgc = sgn; sc = 1'b1; end
        endcase
        @(posedge clk); #1;
        sa = 1'b0; sb = 1'b0; sc = 1'b0;
        chk({tag, "_busy_after_accept"}, 32'(busy_of(sel)), 32'd1);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (rdy_of(sel)) begin
                lat = n;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        case (sel)
            0:       begin bcd_o = {8'd0, bcd_a}; s_o = sign_a; ov_o = ov_a; end
            1:       begin bcd_o = {12'd0, bcd_b}; s_o = sign_b; ov_o = ov_b; end
            default: begin bcd_o = bcd_c; s_o = sign_c; ov_o = ov_c; end
        endcase
        chk({tag, "_busy_at_ready"}, 32'(busy_of(sel)), 32'd1);
        @(posedge clk); #1;
        chk({tag, "_ready_one_cycle"}, 32'(rdy_of(sel)), 32'd0);
        chk({tag, "_busy_released"}, 32'(busy_of(sel)), 32'd0);
    endtask

    initial begin
        logic [19:0] r_bcd;
        logic        r_s;
        logic        r_ov;
        int          pulses;
        int          early;

        rst = 1'b0;
        sa = 1'b0; sga = 1'b0; ba = '0;
        sb = 1'b0; sgb = 1'b0; bb = '0;
        sc = 1'b0; sgc = 1'b0; bc = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bcd_a",  32'(bcd_a),  32'd0);
        chk("reset_sign_a", 32'(sign_a), 32'd0);
        chk("reset_ov_a",   32'(ov_a),   32'd0);
        chk("reset_busy_a", 32'(busy_a), 32'd0);
        chk("reset_rdy_a",  32'(rdy_a),  32'd0);
        chk("reset_bcd_c",  32'(bcd_c),  32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Basic unsigned conversions
        convert(0, 16'd123, 1'b0, 9, "a123", r_bcd, r_s, r_ov);
        chk("a123_bcd", 32'(r_bcd), 32'h123);
        chk("a123_sign", 32'(r_s), 32'd0);
        chk("a123_ov", 32'(r_ov), 32'd0);
        convert(0, 16'd38, 1'b0, 9, "a38", r_bcd, r_s, r_ov);
        chk("a38_bcd", 32'(r_bcd), 32'h038);

        // Signed versus unsigned interpretation
        convert(0, 16'h00FF, 1'b0, 9, "aFFu", r_bcd, r_s, r_ov);
        chk("aFFu_bcd", 32'(r_bcd), 32'h255);
        chk("aFFu_sign", 32'(r_s), 32'd0);
        convert(0, 16'h00FF, 1'b1, 9, "aFFs", r_bcd, r_s, r_ov);
        chk("aFFs_bcd", 32'(r_bcd), 32'h001);
        chk("aFFs_sign", 32'(r_s), 32'd1);
        convert(0, 16'h0080, 1'b1, 9, "a80s", r_bcd, r_s, r_ov);
        chk("a80s_bcd", 32'(r_bcd), 32'h128);
        chk("a80s_sign", 32'(r_s), 32'd1);
        chk("a80s_ov", 32'(r_ov), 32'd0);

        // Overflow with two digits
        convert(1, 16'd123, 1'b0, 9, "b123", r_bcd, r_s, r_ov);
        chk("b123_bcd", 32'(r_bcd), 32'h23);
        chk("b123_ov", 32'(r_ov), 32'd1);
        convert(1, 16'd99, 1'b0, 9, "b99", r_bcd, r_s, r_ov);
        chk("b99_bcd", 32'(r_bcd), 32'h99);
        chk("b99_ov", 32'(r_ov), 32'd0);

        // Wide instance
        convert(2, 16'hFFFF, 1'b0, 17, "c65535", r_bcd, r_s, r_ov);
        chk("c65535_bcd", 32'(r_bcd), 32'h65535);
        chk("c65535_sign", 32'(r_s), 32'd0);
        chk("c65535_ov", 32'(r_ov), 32'd0);
        convert(2, 16'h8000, 1'b1, 17, "c8000s", r_bcd, r_s, r_ov);
        chk("c8000s_bcd", 32'(r_bcd), 32'h32768);
        chk("c8000s_sign", 32'(r_s), 32'd1);

        // Start while busy is ignored
        @(negedge clk);
        ba = 8'd200; sga = 1'b0; sa = 1'b1;
        @(posedge clk); #1;
        sa = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        ba = 8'd7; sa = 1'b1;
        @(negedge clk);
        sa = 1'b0;
        pulses = 0;
        early  = 0;
        for (int n = 0; n < 24; n++) begin
            @(posedge clk); #1;
            if (rdy_a) pulses++;
            if (!busy_a && pulses == 0) early = 1;
        end
        chk("busy_start_pulses", 32'(pulses), 32'd1);
        chk("busy_start_bcd", 32'(bcd_a), 32'h200);
        chk("busy_start_no_early_drop", 32'(early), 32'd0);

        // Reset mid-conversion
        @(negedge clk);
        ba = 8'd123; sga = 1'b0; sa = 1'b1;
        @(posedge clk); #1;
        sa = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_bcd", 32'(bcd_a), 32'd0);
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_rdy", 32'(rdy_a), 32'd0);
        chk("midrst_sign", 32'(sign_a), 32'd0);
        chk("midrst_ov", 32'(ov_a), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            if (rdy_a) pulses++;
        end
        chk("midrst_no_ready", 32'(pulses), 32'd0);
        convert(0, 16'd45, 1'b0, 9, "a45", r_bcd, r_s, r_ov);
        chk("a45_bcd", 32'(r_bcd), 32'h045);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
